// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
// Width functions, a power-of-two test for elaboration checks, and the flag bundle.
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_CLEAR = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage array: one synchronous write port and one
// synchronous read port with a registered output; contents are never reset.
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, full/empty/almost flags,
// overflow/underflow pulses and a synchronous flush.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      write_enable,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      read_enable,
    output logic [DATA_W-1:0]         data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_param: DATA_W must be at least 1");
    end
    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    fifo_flags_t       flags_reg, flags_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;
    logic              out_valid_reg;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Acceptance is decided from the flags registered at the start of the cycle,
    // so a full FIFO can still drain while the same-cycle write is rejected.
    always_comb begin
        wr_acc         = 1'b0;
        rd_acc         = 1'b0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (!flush) begin
            wr_acc         = write_enable && !flags_reg.full;
            rd_acc         = read_enable  && !flags_reg.empty;
            overflow_next  = write_enable && flags_reg.full;
            underflow_next = read_enable  && flags_reg.empty;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            count_next = count_reg + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    always_comb begin
        flags_next              = FLAGS_CLEAR;
        flags_next.full         = (count_next == CW'(DEPTH));
        flags_next.empty        = (count_next == '0);
        flags_next.almost_full  = (int'(count_next) >= AF_LEVEL);
        flags_next.almost_empty = (int'(count_next) <= AE_LEVEL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            flags_reg     <= FLAGS_CLEAR;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            flags_reg     <= flags_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // The storage output has no reset; this bit forces data_out to zero until
    // the first accepted read after reset has loaded real data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
        end else if (rd_acc) begin
            out_valid_reg <= 1'b1;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    assign data_out     = out_valid_reg ? mem_rdata : '0;
    assign full         = flags_reg.full;
    assign empty        = flags_reg.empty;
    assign almost_full  = flags_reg.almost_full;
    assign almost_empty = flags_reg.almost_empty;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: directed scenarios on an 8x8 FIFO and a long random run
// on a 32x16 FIFO, both compared against queue-based reference models.
module tb_sync_fifo_param;

    localparam int AW = 8,  AD = 8,  AAF = 6,  AAE = 2;
    localparam int BW = 32, BD = 16, BAF = 15, BAE = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_flush = 1'b0, a_we = 1'b0, a_re = 1'b0;
    logic [AW-1:0] a_din = '0, a_dout;
    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0]    a_count;

    logic          b_flush = 1'b0, b_we = 1'b0, b_re = 1'b0;
    logic [BW-1:0] b_din = '0, b_dout;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [4:0]    b_count;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] qa[$];
    logic [AW-1:0] ea_dout = '0;
    bit            ea_ovf = 1'b0, ea_unf = 1'b0;
    logic [BW-1:0] qb[$];
    logic [BW-1:0] eb_dout = '0;
    bit            eb_ovf = 1'b0, eb_unf = 1'b0;

    sync_fifo_param #(.DATA_W(AW), .DEPTH(AD), .AF_LEVEL(AAF), .AE_LEVEL(AAE)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush),
        .write_enable(a_we), .data_in(a_din), .read_enable(a_re),
        .data_out(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_param #(.DATA_W(BW), .DEPTH(BD), .AF_LEVEL(BAF), .AE_LEVEL(BAE)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush),
        .write_enable(b_we), .data_in(b_din), .read_enable(b_re),
        .data_out(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    // One clock of traffic on the small FIFO; the model then applies the
    // FIFO rules to the occupancy seen before the edge.
    task automatic drive_a(input bit wr, input logic [AW-1:0] d, input bit rd, input bit fl);
        bit was_full, was_empty;
        a_we = wr; a_din = d; a_re = rd; a_flush = fl;
        @(posedge clk);
        #1;
        was_full  = (qa.size() == AD);
        was_empty = (qa.size() == 0);
        if (fl) begin
            qa.delete();
            ea_ovf = 1'b0;
            ea_unf = 1'b0;
        end else begin
            ea_ovf = wr && was_full;
            ea_unf = rd && was_empty;
            if (rd && !was_empty) ea_dout = qa.pop_front();
            if (wr && !was_full) qa.push_back(d);
        end
        a_we = 1'b0; a_re = 1'b0; a_flush = 1'b0;
        $display("[%0t] A wr=%0b din=%02h rd=%0b fl=%0b -> dout=%02h count=%0d ovf=%0b unf=%0b",
                 $time, wr, d, rd, fl, a_dout, a_count, a_ovf, a_unf);
    endtask

    task automatic drive_b(input bit wr, input logic [BW-1:0] d, input bit rd, input bit fl);
        bit was_full, was_empty;
        b_we = wr; b_din = d; b_re = rd; b_flush = fl;
        @(posedge clk);
        #1;
        was_full  = (qb.size() == BD);
        was_empty = (qb.size() == 0);
        if (fl) begin
            qb.delete();
            eb_ovf = 1'b0;
            eb_unf = 1'b0;
        end else begin
            eb_ovf = wr && was_full;
            eb_unf = rd && was_empty;
            if (rd && !was_empty) eb_dout = qb.pop_front();
            if (wr && !was_full) qb.push_back(d);
        end
        b_we = 1'b0; b_re = 1'b0; b_flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", a_full); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", a_dout); end
        checks++; if (a_ae !== 1'b1 || a_af !== 1'b0) begin errors++; $display("FAIL reset_almost got=ae%0b/af%0b exp=ae1/af0", a_ae, a_af); end
        checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL reset_err got=ovf%0b/unf%0b exp=0/0", a_ovf, a_unf); end
        checks++; if (b_empty !== 1'b1 || b_count !== 5'd0) begin errors++; $display("FAIL reset_b got=empty%0b/count%0d exp=1/0", b_empty, b_count); end
        reset_n = 1'b1;
        qa.delete(); ea_dout = '0;
        drive_a(1'b1, 8'h11, 1'b0, 1'b0);
        drive_a(1'b1, 8'h22, 1'b0, 1'b0);
        drive_a(1'b1, 8'h33, 1'b1, 1'b0);
        checks++; if (a_dout !== 8'h11) begin errors++; $display("FAIL pre_reset_read got=%h exp=11", a_dout); end
        // Assert reset between edges: outputs must clear without a clock.
        #2 reset_n = 1'b0;
        #1;
        checks++; if (a_empty !== 1'b1 || a_count !== 4'd0) begin errors++; $display("FAIL async_reset_state got=empty%0b/count%0d exp=1/0", a_empty, a_count); end
        checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL async_reset_dout got=%h exp=00", a_dout); end
        #1 reset_n = 1'b1;
        qa.delete(); ea_dout = '0; ea_ovf = 1'b0; ea_unf = 1'b0;
        drive_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (a_unf !== 1'b1 || a_unf !== ea_unf) begin errors++; $display("FAIL post_reset_underflow got=%0b exp=1", a_unf); end
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL underflow_one_cycle got=%0b exp=0", a_unf); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= AD; i++) begin
            drive_a(1'b1, 8'(i), 1'b0, 1'b0);
            checks++; if (a_count !== 4'(i)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", a_count, i); end
            checks++; if (a_af !== (i >= AAF) || a_ae !== (i <= AAE)) begin errors++; $display("FAIL fill_almost got=af%0b/ae%0b exp=af%0b/ae%0b", a_af, a_ae, i >= AAF, i <= AAE); end
            checks++; if (a_full !== (i == AD) || a_empty !== 1'b0) begin errors++; $display("FAIL fill_full got=full%0b/empty%0b exp=%0b/0", a_full, a_empty, i == AD); end
        end
        for (int i = 1; i <= AD; i++) begin
            drive_a(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (a_dout !== 8'(i)) begin errors++; $display("FAIL drain_data got=%h exp=%h", a_dout, 8'(i)); end
            checks++; if (a_count !== 4'(AD - i) || a_empty !== (i == AD)) begin errors++; $display("FAIL drain_count got=%0d/empty%0b exp=%0d/%0b", a_count, a_empty, AD - i, i == AD); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= AD; i++) drive_a(1'b1, 8'(i), 1'b0, 1'b0);
        drive_a(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL overflow_pulse got=%0b exp=1", a_ovf); end
        checks++; if (a_count !== 4'd8 || a_full !== 1'b1) begin errors++; $display("FAIL overflow_count got=%0d/full%0b exp=8/1", a_count, a_full); end
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle got=%0b exp=0", a_ovf); end
        for (int i = 1; i <= AD; i++) begin
            drive_a(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (a_dout !== 8'(i)) begin errors++; $display("FAIL overflow_drain got=%h exp=%h", a_dout, 8'(i)); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) drive_a(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive_a(1'b1, 8'($urandom), 1'b1, 1'b0);
            checks++; if (a_count !== 4'd3) begin errors++; $display("FAIL simul_count got=%0d exp=3", a_count); end
            checks++; if (a_dout !== ea_dout) begin errors++; $display("FAIL simul_order got=%h exp=%h", a_dout, ea_dout); end
        end
        for (int i = 0; i < 5; i++) drive_a(1'b1, 8'($urandom), 1'b0, 1'b0);
        drive_a(1'b1, 8'h5C, 1'b1, 1'b0);
        checks++; if (a_count !== 4'd7 || a_ovf !== 1'b1) begin errors++; $display("FAIL full_wr_rd got=count%0d/ovf%0b exp=7/1", a_count, a_ovf); end
        checks++; if (a_dout !== ea_dout) begin errors++; $display("FAIL full_wr_rd_data got=%h exp=%h", a_dout, ea_dout); end
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (a_dout !== ea_dout) begin errors++; $display("FAIL simul_drain got=%h exp=%h", a_dout, ea_dout); end
        end
        drive_a(1'b1, 8'h77, 1'b1, 1'b0);
        checks++; if (a_count !== 4'd1 || a_unf !== 1'b1) begin errors++; $display("FAIL empty_wr_rd got=count%0d/unf%0b exp=1/1", a_count, a_unf); end
        drive_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (a_dout !== 8'h77) begin errors++; $display("FAIL empty_wr_rd_data got=%h exp=77", a_dout); end
    endtask

    task automatic test_flush();
        logic [AW-1:0] held;
        for (int i = 0; i < 5; i++) drive_a(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        held = ea_dout;
        drive_a(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (a_count !== 4'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL flush_state got=count%0d/empty%0b exp=0/1", a_count, a_empty); end
        checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL flush_pulses got=ovf%0b/unf%0b exp=0/0", a_ovf, a_unf); end
        checks++; if (a_dout !== held) begin errors++; $display("FAIL flush_dout_hold got=%h exp=%h", a_dout, held); end
        drive_a(1'b1, 8'h5A, 1'b0, 1'b0);
        drive_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (a_dout !== 8'h5A) begin errors++; $display("FAIL flush_new_word got=%h exp=5a", a_dout); end
        checks++; if (a_count !== 4'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL flush_after got=count%0d/empty%0b exp=0/1", a_count, a_empty); end
    endtask

    task automatic test_random_wide();
        int wr_pct, rd_pct, n;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // Alternate write-heavy and read-heavy phases so both full and empty are hit.
            wr_pct = ((cyc / 300) % 2 == 0) ? 70 : 30;
            rd_pct = 100 - wr_pct;
            drive_b($urandom_range(0, 99) < wr_pct, $urandom, $urandom_range(0, 99) < rd_pct,
                    $urandom_range(0, 999) == 0);
            n = qb.size();
            checks++; if (b_dout !== eb_dout) begin errors++; $display("FAIL wide_data cyc=%0d got=%h exp=%h", cyc, b_dout, eb_dout); end
            checks++; if (b_count !== 5'(n)) begin errors++; $display("FAIL wide_count cyc=%0d got=%0d exp=%0d", cyc, b_count, n); end
            checks++; if (b_full !== (n == BD) || b_empty !== (n == 0)) begin errors++; $display("FAIL wide_full_empty cyc=%0d got=%0b%0b exp=%0b%0b", cyc, b_full, b_empty, n == BD, n == 0); end
            checks++; if (b_af !== (n >= BAF) || b_ae !== (n <= BAE)) begin errors++; $display("FAIL wide_almost cyc=%0d got=%0b%0b exp=%0b%0b", cyc, b_af, b_ae, n >= BAF, n <= BAE); end
            checks++; if (b_ovf !== eb_ovf || b_unf !== eb_unf) begin errors++; $display("FAIL wide_err cyc=%0d got=%0b%0b exp=%0b%0b", cyc, b_ovf, b_unf, eb_ovf, eb_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_random_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
